packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/packet_injector.sv | 152 +++++++++++++++
 tb/tb_packet_injector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_injector.sv
// Packs up to three source words into one routed mesh packet and delivers it over a 4-phase req/ack handshake.
// Optional macro PKT_INJ_ACK_SYNC_EN inserts a two-flop synchronizer on pkt_ack for an asynchronous mesh.
module packet_injector #(
    parameter int         FILTER_WIDTH = 8,
    parameter int         WIDTH        = 9 + 3 * FILTER_WIDTH,
    parameter logic [4:0] ROUTE0       = 5'h1A,
    parameter logic [4:0] ROUTE1       = 5'h1C,
    parameter logic [4:0] ROUTE2       = 5'h09,
    parameter logic [4:0] ROUTE3       = 5'h0B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic [FILTER_WIDTH-1:0] word_data,
    input  logic [1:0]              word_type,
    input  logic [1:0]              word_node,
    input  logic                    word_last,
    output logic [WIDTH-1:0]        pkt_data,
    output logic                    pkt_req,
    input  logic                    pkt_ack,
    output logic                    busy
);

    localparam int LW = 3 * FILTER_WIDTH;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [LW-1:0]     r_lanes;
    logic [1:0]        r_type;
    logic [1:0]        r_node;
    logic [WIDTH-1:0]  r_pkt_data;
    logic              r_req;
    logic              r_busy;

    logic              w_ack;
    logic              w_accept;
    logic              w_done;
    logic [LW-1:0]     w_lanes;
    logic [1:0]        w_type;
    logic [1:0]        w_node;
    logic [4:0]        w_route;
    logic [WIDTH-1:0]  w_pkt;

`ifdef PKT_INJ_ACK_SYNC_EN
    logic r_ack_meta;
    logic r_ack_sync;

    // Two-flop synchronizer bringing the mesh acknowledge into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= pkt_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack = r_ack_sync;
`else
    assign w_ack = pkt_ack;
`endif

    // A completing word can never launch a new request while the mesh still shows ack high
    assign word_ready = (r_state == FILL) & ~w_ack;
    assign w_accept   = word_valid & word_ready;
    assign w_done     = (r_cnt == 2'd2) | word_last;

    // Next group contents: first word starts a clean group and captures type/node
    always_comb begin
        w_lanes = (r_cnt == 2'd0) ? {LW{1'b0}} : r_lanes;
        w_lanes[int'(r_cnt) * FILTER_WIDTH +: FILTER_WIDTH] = word_data;
        if (r_cnt == 2'd0) begin
            w_type = word_type;
            w_node = word_node;
        end else begin
            w_type = r_type;
            w_node = r_node;
        end
        case (w_node)
            2'd0:    w_route = ROUTE0;
            2'd1:    w_route = ROUTE1;
            2'd2:    w_route = ROUTE2;
            2'd3:    w_route = ROUTE3;
            default: w_route = ROUTE0;
        endcase
        w_pkt = WIDTH'({w_route, w_type, w_node, w_lanes});
    end

    // Group fill and 4-phase handshake FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_cnt      <= 2'd0;
            r_lanes    <= {LW{1'b0}};
            r_type     <= 2'd0;
            r_node     <= 2'd0;
            r_pkt_data <= {WIDTH{1'b0}};
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept && w_done) begin
                        r_pkt_data <= w_pkt;
                        r_req      <= 1'b1;
                        r_state    <= REQ_HI;
                        r_cnt      <= 2'd0;
                        r_lanes    <= {LW{1'b0}};
                        r_busy     <= 1'b1;
                    end else if (w_accept) begin
                        r_lanes    <= w_lanes;
                        r_type     <= w_type;
                        r_node     <= w_node;
                        r_cnt      <= r_cnt + 2'd1;
                        r_busy     <= 1'b1;
                    end
                end
                REQ_HI: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!w_ack) begin
                        r_state <= FILL;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_cnt   <= 2'd0;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_data = r_pkt_data;
    assign pkt_req  = r_req;
    assign busy     = r_busy;

endmodule

// File: tb/tb_packet_injector.sv
// Scoreboard bench for packet_injector: expected packets are queued as words are driven and popped on each pkt_req rise.
module tb_packet_injector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  word_data;
    logic [1:0]  word_type;
    logic [1:0]  word_node;
    logic        word_last;
    logic [32:0] pkt_data;
    logic        pkt_req;
    logic        pkt_ack;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] sb[$];
    logic        ack_en = 1'b1;
    logic        req_q = 1'b0;

    // Bench-side group model
    int          m_cnt = 0;
    logic [7:0]  m_lane[3];
    logic [1:0]  m_type;
    logic [1:0]  m_node;

    packet_injector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_type  (word_type),
        .word_node  (word_node),
        .word_last  (word_last),
        .pkt_data   (pkt_data),
        .pkt_req    (pkt_req),
        .pkt_ack    (pkt_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] route_of(input logic [1:0] node);
        case (node)
            2'd0:    return 5'h1A;
            2'd1:    return 5'h1C;
            2'd2:    return 5'h09;
            default: return 5'h0B;
        endcase
    endfunction

    // Immediate responder: ack follows req one half-cycle later
    always @(negedge clk) begin
        if (ack_en) pkt_ack = pkt_req;
    end

    // Pop and compare on every pkt_req rise
    always @(posedge clk) begin
        #1;
        if (pkt_req && !req_q) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("pkt_data", {31'd0, pkt_data}, {31'd0, sb.pop_front()});
        end
        req_q = pkt_req;
    end

    task automatic send(input logic [7:0] d, input logic [1:0] t, input logic [1:0] n, input logic l);
        int   k;
        logic done;
        word_valid = 1'b1;
        word_data  = d;
        word_type  = t;
        word_node  = n;
        word_last  = l;
        k = 0;
        while (!word_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) chk("ready_timeout", 64'd0, 64'd1);
        if (m_cnt == 0) begin
            m_type  = t;
            m_node  = n;
            m_lane[0] = 8'h00; m_lane[1] = 8'h00; m_lane[2] = 8'h00;
        end
        m_lane[m_cnt] = d;
        m_cnt++;
        done = (m_cnt == 3) || l;
        if (done) begin
            sb.push_back({route_of(m_node), m_type, m_node, m_lane[2], m_lane[1], m_lane[0]});
            m_cnt = 0;
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        chk("req_at_accept", {63'd0, pkt_req}, {63'd0, done});
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || !word_ready) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 200) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          c;
        int          exp_lat;
        logic [32:0] hold;
        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_data  = 8'h00;
        word_type  = 2'd0;
        word_node  = 2'd0;
        word_last  = 1'b0;
        pkt_ack    = 1'b0;
        #1;
        chk("rst_req",  {63'd0, pkt_req}, 64'd0);
        chk("rst_data", {31'd0, pkt_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, word_ready}, 64'd1);

        // Full group to node1, type 01
        send(8'h11, 2'b01, 2'd1, 1'b0);
        chk("busy_partial", {63'd0, busy}, 64'd1);
        send(8'h22, 2'b10, 2'd3, 1'b0);
        send(8'h33, 2'b00, 2'd0, 1'b0);
        wait_idle();

        // Single-word group flushed by word_last
        send(8'hAB, 2'b10, 2'd2, 1'b1);
        wait_idle();

        // Handshake held open: everything must freeze
        ack_en = 1'b0;
        send(8'h5A, 2'b11, 2'd0, 1'b0);
        send(8'hC3, 2'b00, 2'd1, 1'b1);
        hold = pkt_data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold_req",   {63'd0, pkt_req}, 64'd1);
            chk("hold_data",  {31'd0, pkt_data}, {31'd0, hold});
            chk("hold_ready", {63'd0, word_ready}, 64'd0);
        end
        ack_en = 1'b1;
        wait_idle();

        // Six back-to-back words to node3
        for (int i = 1; i <= 6; i++) send(8'(i), 2'b00, 2'd3, 1'b0);
        wait_idle();

        // Return latency after the ack toggles
`ifdef PKT_INJ_ACK_SYNC_EN
        exp_lat = 6;
`else
        exp_lat = 2;
`endif
        send(8'h77, 2'b01, 2'd2, 1'b1);
        c = 0;
        while (!word_ready && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("return_latency", 64'(c), 64'(exp_lat));
        wait_idle();

        // Reset while in REQ_HI abandons the packet with no clock edge
        ack_en = 1'b0;
        send(8'hE1, 2'b11, 2'd0, 1'b0);
        send(8'hE2, 2'b11, 2'd0, 1'b0);
        send(8'hE3, 2'b11, 2'd0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",  {63'd0, pkt_req}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_data", {31'd0, pkt_data}, 64'd0);
        m_cnt = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_mid_rst", {63'd0, word_ready}, 64'd1);

        // Fresh packet after the abandoned one
        send(8'h42, 2'b01, 2'd3, 1'b1);
        wait_idle();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
